// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned multiply / divide engine.
// Shift-add multiply and restoring divide, one radix-2 step per clock.
// Operands are latched when a start is accepted. The 2*WIDTH result is
// registered and announced by a one-cycle done strobe.
module muldiv_unit #(
  parameter int          WIDTH  = 32,
  parameter logic [3:0]  MUL_OP = 4'h2,
  parameter logic [3:0]  DIV_OP = 4'h3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;       // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0]   opb_q, opb_d;       // divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;       // product accumulator; low half starts as multiplier
  logic [WIDTH:0]     rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               dbz_q, dbz_d;

  logic               is_mul_s;
  logic               is_div_s;
  logic               can_accept_s;
  logic               accept_s;
  logic               b_zero_s;
  logic               last_s;

  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic               div_neg_s;
  logic [WIDTH:0]     div_rem_s;
  logic [WIDTH-1:0]   div_quo_s;

  assign is_mul_s     = (aluop == MUL_OP);
  assign is_div_s     = (aluop == DIV_OP);
  assign can_accept_s = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept_s     = start && can_accept_s && (is_mul_s || is_div_s);
  assign b_zero_s     = (b == {WIDTH{1'b0}});
  assign last_s       = (cnt_q == CNT_ONE);

  // Multiply step: add multiplicand to the upper half when the multiplier
  // LSB (acc_q[0]) is set, then shift the whole accumulator right by one.
  assign mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
  assign mul_acc_s = {mul_sum_s, acc_q[WIDTH-1:1]};

  // Divide step: shift in the next dividend MSB, trial-subtract the divisor,
  // keep the shifted value when the difference is negative.
  assign div_shift_s = (rem_q << 1) | {{WIDTH{1'b0}}, opa_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opb_q};
  assign div_neg_s   = div_diff_s[WIDTH];
  assign div_rem_s   = div_neg_s ? div_shift_s : div_diff_s;
  assign div_quo_s   = {opa_q[WIDTH-2:0], ~div_neg_s};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (is_div_s && b_zero_s) begin
            state_d = S_DONE;
          end else if (is_mul_s) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DIV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: busy while iterating, done only in the completion state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_MUL:   busy = 1'b1;
      S_DIV:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next values: latch on accept, iterate, capture results on the last step.
  always_comb begin
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          opa_d = a;
          opb_d = b;
          cnt_d = CNT_LOAD;
          acc_d = {{WIDTH{1'b0}}, b};
          rem_d = {(WIDTH+1){1'b0}};
          if (is_div_s && b_zero_s) begin
            res_lo_d = {WIDTH{1'b1}};
            res_hi_d = a;
            dbz_d    = 1'b1;
          end else begin
            dbz_d    = dbz_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_MUL: begin
        acc_d = mul_acc_s;
        cnt_d = cnt_q - CNT_ONE;
        if (last_s) begin
          res_lo_d = mul_acc_s[WIDTH-1:0];
          res_hi_d = mul_acc_s[2*WIDTH-1:WIDTH];
          dbz_d    = 1'b0;
        end else begin
          dbz_d    = dbz_q;
        end
      end
      S_DIV: begin
        rem_d = div_rem_s;
        opa_d = div_quo_s;
        cnt_d = cnt_q - CNT_ONE;
        if (last_s) begin
          res_lo_d = div_quo_s;
          res_hi_d = div_rem_s[WIDTH-1:0];
          dbz_d    = 1'b0;
        end else begin
          dbz_d    = dbz_q;
        end
      end
      default: begin
        cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // Datapath and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= {CW{1'b0}};
      opa_q    <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      rem_q    <= {(WIDTH+1){1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
      res_hi_q <= {WIDTH{1'b0}};
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit with hand-computed expected values.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        div_by_zero;

  int checks;
  int failures;

  muldiv_unit #(.WIDTH(32), .MUL_OP(4'h2), .DIV_OP(4'h3)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse, sampled at the following rising edge, then scramble operands.
  task automatic start_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; aluop = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; aluop = 4'h0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  // Wait (bounded) for done; report edges after the start edge and busy cycles seen.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0; busy_cycles = 0;
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; aluop = 4'h0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if ({result_hi, result_lo} !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", {result_hi, result_lo}); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%0b exp=0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_mul_basic();
    int e, bc;
    start_op(4'h2, 32'd7, 32'd6);
    wait_done(e, bc);
    checks++; if (e !== 32) begin failures++; $display("FAIL mul_latency got=%0d exp=32", e); end
    checks++; if (bc !== 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", bc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy_in_done got=%0b exp=0", busy); end
    checks++; if (result_lo !== 32'd42) begin failures++; $display("FAIL mul_7x6_lo got=%0d exp=42", result_lo); end
    checks++; if (result_hi !== 32'd0) begin failures++; $display("FAIL mul_7x6_hi got=%0d exp=0", result_hi); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL mul_7x6_dbz got=%0b exp=0", div_by_zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mul_done_width got=%0b exp=0", done); end
  endtask

  task automatic test_mul_max();
    int e, bc;
    start_op(4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(e, bc);
    checks++; if (result_hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mul_max_hi got=%h exp=fffffffe", result_hi); end
    checks++; if (result_lo !== 32'h0000_0001) begin failures++; $display("FAIL mul_max_lo got=%h exp=00000001", result_lo); end
  endtask

  task automatic test_div();
    int e, bc;
    start_op(4'h3, 32'd100, 32'd7);
    wait_done(e, bc);
    checks++; if (e !== 32) begin failures++; $display("FAIL div_latency got=%0d exp=32", e); end
    checks++; if (result_lo !== 32'd14) begin failures++; $display("FAIL div_100_7_q got=%0d exp=14", result_lo); end
    checks++; if (result_hi !== 32'd2) begin failures++; $display("FAIL div_100_7_r got=%0d exp=2", result_hi); end
    start_op(4'h3, 32'd5, 32'd9);
    wait_done(e, bc);
    checks++; if (result_lo !== 32'd0) begin failures++; $display("FAIL div_5_9_q got=%0d exp=0", result_lo); end
    checks++; if (result_hi !== 32'd5) begin failures++; $display("FAIL div_5_9_r got=%0d exp=5", result_hi); end
    start_op(4'h3, 32'hFFFF_FFFF, 32'h0001_0000);
    wait_done(e, bc);
    checks++; if ({result_hi, result_lo} !== {32'h0000_FFFF, 32'h0000_FFFF}) begin failures++; $display("FAIL div_big got=%h exp=0000ffff0000ffff", {result_hi, result_lo}); end
  endtask

  task automatic test_div_zero();
    int e, bc;
    start_op(4'h3, 32'd5, 32'd0);
    wait_done(e, bc);
    checks++; if (e !== 0) begin failures++; $display("FAIL dz_latency got=%0d exp=0", e); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dz_busy got=%0b exp=0", busy); end
    checks++; if (result_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_lo got=%h exp=ffffffff", result_lo); end
    checks++; if (result_hi !== 32'd5) begin failures++; $display("FAIL dz_hi got=%0d exp=5", result_hi); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%0b exp=1", div_by_zero); end
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL dz_after got=%b exp=00", {busy, done}); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_hold got=%0b exp=1", div_by_zero); end
  endtask

  task automatic test_ignored_starts();
    int e, bc, hits;
    start_op(4'h2, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; aluop = 4'h2; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; aluop = 4'h0;
    wait_done(e, bc);
    checks++; if (e + 10 !== 32) begin failures++; $display("FAIL ign_latency got=%0d exp=32", e + 10); end
    checks++; if (result_lo !== 32'd12) begin failures++; $display("FAIL ign_mul_lo got=%0d exp=12", result_lo); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL ign_dbz_cleared got=%0b exp=0", div_by_zero); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; aluop = 4'h4; a = 32'd11; b = 32'd11;
    @(posedge clk); #1;
    start = 1'b0; aluop = 4'h0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1 || done === 1'b1) hits++;
      @(posedge clk); #1;
    end
    checks++; if (hits !== 0) begin failures++; $display("FAIL ign_activity got=%0d exp=0", hits); end
    checks++; if ({result_hi, result_lo} !== 64'd12) begin failures++; $display("FAIL ign_hold got=%h exp=12", {result_hi, result_lo}); end
  endtask

  task automatic test_abort();
    int e, bc, hits;
    start_op(4'h2, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin failures++; $display("FAIL abort_flags got=%b exp=000", {busy, done, div_by_zero}); end
    checks++; if ({result_hi, result_lo} !== 64'd0) begin failures++; $display("FAIL abort_result got=%h exp=0", {result_hi, result_lo}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) hits++;
      @(posedge clk); #1;
    end
    checks++; if (hits !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", hits); end
    start_op(4'h2, 32'd2, 32'd5);
    wait_done(e, bc);
    checks++; if (result_lo !== 32'd10) begin failures++; $display("FAIL abort_next_mul got=%0d exp=10", result_lo); end
  endtask

  task automatic test_back_to_back();
    int e, bc;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_pre_done got=%0b exp=1", done); end
    start_op(4'h3, 32'd100, 32'd7);
    checks++; if ({busy, done} !== 2'b10) begin failures++; $display("FAIL b2b_accept got=%b exp=10", {busy, done}); end
    wait_done(e, bc);
    checks++; if (e !== 32) begin failures++; $display("FAIL b2b_latency got=%0d exp=32", e); end
    checks++; if (result_lo !== 32'd14) begin failures++; $display("FAIL b2b_q got=%0d exp=14", result_lo); end
    checks++; if (result_hi !== 32'd2) begin failures++; $display("FAIL b2b_r got=%0d exp=2", result_hi); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mul_basic();
    test_mul_max();
    test_div();
    test_div_zero();
    test_ignored_starts();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
